// File: rtl/uart_byte_fifo.sv
// Show-ahead byte FIFO between a UART receiver and transmitter.
// Valid/ready on both sides, synchronous flush, count and almost_full.
module uart_byte_fifo #(
    parameter int DEPTH       = 16,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [7:0]               in_byte,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [7:0]               out_byte,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push;
    logic          pop;

    always_comb begin
        in_ready    = (count_q < CW'(DEPTH)) && !flush;
        out_valid   = (count_q != '0);
        out_byte    = mem[rd_ptr_q];
        count       = count_q;
        almost_full = (count_q >= CW'(AFULL_LEVEL));
        push        = in_valid && in_ready;
        pop         = out_valid && out_ready;
    end

    // Flush wins over any handshake on the same edge.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; out_byte is ignored while out_valid is low.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_q] <= in_byte;
    end

endmodule
